// File: rtl/xmul_row_seq.sv
// xmul_row_seq: sequences one operand-scanning row r = a*b + c through
// the shared 2-stage MADDL/MADDH unit, 3 cycles per limb.
module xmul_row_seq #(
    parameter int N  = 9,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [63:0]   b_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] a_addr,
    input  logic [63:0]   a_rdata,
    output logic [AW-1:0] c_addr,
    input  logic [63:0]   c_rdata,
    output logic          r_we,
    output logic [AW-1:0] r_addr,
    output logic [63:0]   r_wdata,
    output logic          mul_req_valid,
    output logic          mul_req_dw,
    output logic [5:0]    mul_req_fn,
    output logic [4:0]    mul_req_tag,
    output logic [63:0]   mul_req_in1,
    output logic [63:0]   mul_req_in2,
    output logic [63:0]   mul_req_in3,
    input  logic [63:0]   mul_resp_data,
    input  logic [4:0]    mul_resp_tag
);

    typedef enum logic [2:0] {IDLE, ISSH, WAIT, ISSL, FIN} state_e;

    localparam logic [5:0]    FN_MADDL = 6'd50;
    localparam logic [5:0]    FN_MADDH = 6'd51;
    localparam logic [AW-1:0] LAST     = AW'(N);

    state_e        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [63:0]   b_q, b_d;
    logic          err_q, err_d;
    logic [1:0]    pend_v_q, pend_v_d;
    logic [AW-1:0] pend0_q, pend0_d;
    logic [AW-1:0] pend1_q, pend1_d;
    logic [AW-1:0] a_addr_q, c_addr_q, r_addr_q;
    logic [63:0]   r_wdata_q, in1_q, in3_q;
    logic [5:0]    fn_q;
    logic [4:0]    tag_q;

    logic          iss_h, iss_l, fin, pend_we, mis;
    logic [4:0]    exp_tag;

    // Datapath outputs: live values while issuing/writing, else hold last value.
    always_comb begin
        iss_h   = (state_q == ISSH);
        iss_l   = (state_q == ISSL);
        fin     = (state_q == FIN);
        pend_we = pend_v_q[1];

        a_addr  = a_addr_q;
        c_addr  = c_addr_q;
        mul_req_in1 = in1_q;
        mul_req_in3 = in3_q;
        mul_req_fn  = fn_q;
        mul_req_tag = tag_q;
        if (iss_h) begin
            a_addr      = i_q - 1'b1;
            c_addr      = i_q;
            mul_req_in1 = (i_q == '0) ? 64'd0 : a_rdata;
            mul_req_in3 = c_rdata;
            mul_req_fn  = FN_MADDH;
            mul_req_tag = {1'b0, 4'(i_q)};
        end else if (iss_l) begin
            a_addr      = i_q;
            mul_req_in1 = a_rdata;
            mul_req_in3 = mul_resp_data;
            mul_req_fn  = FN_MADDL;
            mul_req_tag = {1'b1, 4'(i_q)};
        end

        mul_req_valid = iss_h | iss_l;
        mul_req_dw    = 1'b1;
        mul_req_in2   = b_q;

        r_we    = fin | pend_we;
        r_addr  = fin ? LAST : (pend_we ? pend1_q : r_addr_q);
        r_wdata = r_we ? mul_resp_data : r_wdata_q;

        busy = (state_q != IDLE);
        done = fin;
        err  = err_q;
    end

    // Next-state: row FSM, write-back pending pipe and sticky tag check.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        b_d      = b_q;
        pend_v_d = {pend_v_q[0], iss_l};
        pend0_d  = iss_l ? i_q : pend0_q;
        pend1_d  = pend0_q;

        exp_tag = 5'd0;
        mis     = 1'b0;
        if (iss_l) begin
            exp_tag = {1'b0, 4'(i_q)};
            mis     = (mul_resp_tag != exp_tag);
        end else if (fin) begin
            exp_tag = {1'b0, 4'(LAST)};
            mis     = (mul_resp_tag != exp_tag);
        end else if (pend_we) begin
            exp_tag = {1'b1, 4'(pend1_q)};
            mis     = (mul_resp_tag != exp_tag);
        end
        err_d = err_q | mis;

        unique case (state_q)
            IDLE: if (start) begin
                state_d = ISSH;
                i_d     = '0;
                b_d     = b_in;
                err_d   = 1'b0;
            end
            ISSH: state_d = WAIT;
            WAIT: state_d = (i_q == LAST) ? FIN : ISSL;
            ISSL: begin
                state_d = ISSH;
                i_d     = i_q + 1'b1;
            end
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and held-output registers; reset aborts a row with no further writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            b_q       <= '0;
            err_q     <= 1'b0;
            pend_v_q  <= '0;
            pend0_q   <= '0;
            pend1_q   <= '0;
            a_addr_q  <= '0;
            c_addr_q  <= '0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            in1_q     <= '0;
            in3_q     <= '0;
            fn_q      <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            b_q       <= b_d;
            err_q     <= err_d;
            pend_v_q  <= pend_v_d;
            pend0_q   <= pend0_d;
            pend1_q   <= pend1_d;
            a_addr_q  <= a_addr;
            c_addr_q  <= c_addr;
            r_addr_q  <= r_addr;
            r_wdata_q <= r_wdata;
            in1_q     <= mul_req_in1;
            in3_q     <= mul_req_in3;
            fn_q      <= mul_req_fn;
            tag_q     <= mul_req_tag;
        end
    end

endmodule

// File: tb/tb_xmul_row_seq.sv
// tb_xmul_row_seq: directed checks of the row sequencer against a
// 2-cycle MADDL/MADDH model and limb register files.
module tb_xmul_row_seq;

    localparam int N  = 9;
    localparam int AW = 4;
    localparam logic [63:0] M57 = 64'h01FF_FFFF_FFFF_FFFF;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [63:0]   b_in = '0;
    logic          busy, done, err;
    logic [AW-1:0] a_addr, c_addr, r_addr;
    logic [63:0]   a_rdata, c_rdata, r_wdata;
    logic          r_we;
    logic          mul_req_valid, mul_req_dw;
    logic [5:0]    mul_req_fn;
    logic [4:0]    mul_req_tag;
    logic [63:0]   mul_req_in1, mul_req_in2, mul_req_in3;
    logic [63:0]   mul_resp_data;
    logic [4:0]    mul_resp_tag;

    logic [63:0] amem [16];
    logic [63:0] cmem [16];

    logic        corrupt = 1'b0;
    logic [3:0]  corrupt_idx = 4'd4;
    logic [63:0] s1_d = '0, s2_d = '0;
    logic [4:0]  s1_t = '0, s2_t = '0;

    int checks = 0;
    int passed = 0;

    logic        tr_v    [64];
    logic [5:0]  tr_fn   [64];
    logic [4:0]  tr_tag  [64];
    logic        tr_dw   [64];
    logic        tr_we   [64];
    logic        tr_err  [64];
    logic        tr_busy [64];
    logic        tr_done [64];
    logic        tr_zero [64];
    logic [63:0] rmem [16];
    int          wcyc [16];
    int          wr_cnt;
    int          done_cyc;

    xmul_row_seq #(.N(N), .AW(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .b_in(b_in),
        .busy(busy), .done(done), .err(err),
        .a_addr(a_addr), .a_rdata(a_rdata),
        .c_addr(c_addr), .c_rdata(c_rdata),
        .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
        .mul_req_valid(mul_req_valid), .mul_req_dw(mul_req_dw),
        .mul_req_fn(mul_req_fn), .mul_req_tag(mul_req_tag),
        .mul_req_in1(mul_req_in1), .mul_req_in2(mul_req_in2),
        .mul_req_in3(mul_req_in3),
        .mul_resp_data(mul_resp_data), .mul_resp_tag(mul_resp_tag)
    );

    always #5 clock = ~clock;

    assign a_rdata = amem[a_addr];
    assign c_rdata = cmem[c_addr];

    always @(posedge clock) begin
        logic [127:0] prod;
        prod = 128'(mul_req_in1) * 128'(mul_req_in2);
        if (mul_req_fn == 6'd50)
            s1_d <= 64'(prod[56:0]) + mul_req_in3;
        else
            s1_d <= prod[120:57] + mul_req_in3;
        s1_t <= mul_req_valid ? mul_req_tag : 5'h1F;
        s2_d <= s1_d;
        if (corrupt && s1_t == {1'b0, corrupt_idx})
            s2_t <= s1_t ^ 5'h10;
        else
            s2_t <= s1_t;
    end

    assign mul_resp_data = s2_d;
    assign mul_resp_tag  = s2_t;

    function automatic logic all_zero();
        return ({a_addr, c_addr, r_addr} == '0) && (r_wdata == '0) &&
               (mul_req_in1 == '0) && (mul_req_in2 == '0) &&
               (mul_req_in3 == '0) && (mul_req_fn == '0) &&
               (mul_req_tag == '0) &&
               ({busy, done, err, r_we, mul_req_valid} == '0);
    endfunction

    task automatic load(input logic [63:0] av, input logic cidx);
        for (int j = 0; j < 16; j++) begin
            amem[j] = av;
            cmem[j] = cidx ? 64'(j) : 64'd0;
        end
    endtask

    task automatic run_row(input logic [63:0] b, input int pulse_at,
                           input int abort_at);
        for (int j = 0; j < 16; j++) begin
            rmem[j] = 64'hDEAD_BEEF_DEAD_BEEF;
            wcyc[j] = -1;
        end
        wr_cnt   = 0;
        done_cyc = -1;
        @(negedge clock);
        b_in  = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        b_in  = 64'h0BAD_0BAD_0BAD_0BAD;
        for (int k = 1; k < 45; k++) begin
            tr_v[k]    = mul_req_valid;
            tr_fn[k]   = mul_req_fn;
            tr_tag[k]  = mul_req_tag;
            tr_dw[k]   = mul_req_dw;
            tr_we[k]   = r_we;
            tr_err[k]  = err;
            tr_busy[k] = busy;
            tr_done[k] = done;
            tr_zero[k] = all_zero();
            if (r_we) begin
                wr_cnt++;
                rmem[r_addr] = r_wdata;
                wcyc[r_addr] = k;
            end
            if (done && done_cyc < 0) done_cyc = k;
            start = (k == pulse_at);
            reset = (k == abort_at);
            @(negedge clock);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (all_zero() !== 1'b1)
            $display("FAIL reset_outputs: busy=%b done=%b err=%b we=%b v=%b fn=%0d tag=%0d need all 0",
                     busy, done, err, r_we, mul_req_valid, mul_req_fn, mul_req_tag);
        else passed++;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, r_we, mul_req_valid} !== 3'b000)
            $display("FAIL reset_idle: busy/we/v=%b need 000", {busy, r_we, mul_req_valid});
        else passed++;
    endtask

    task automatic test_basic();
        load(64'd1, 1'b0);
        run_row(64'd2, -1, -1);
        for (int j = 0; j < N; j++) begin
            checks++;
            if (rmem[j] !== 64'd2)
                $display("FAIL basic_r%0d: got %h need 2", j, rmem[j]);
            else passed++;
            checks++;
            if (wcyc[j] !== 5 + 3 * j)
                $display("FAIL basic_wcyc%0d: got %0d need %0d", j, wcyc[j], 5 + 3 * j);
            else passed++;
        end
        checks++;
        if (rmem[N] !== 64'd0)
            $display("FAIL basic_rN: got %h need 0", rmem[N]);
        else passed++;
        checks++;
        if (done_cyc !== 30)
            $display("FAIL basic_done_cycle: got %0d need 30", done_cyc);
        else passed++;
        checks++;
        if (wcyc[N] !== 30)
            $display("FAIL basic_rN_cycle: got %0d need 30", wcyc[N]);
        else passed++;
        checks++;
        if (wr_cnt !== 10)
            $display("FAIL basic_write_count: got %0d need 10", wr_cnt);
        else passed++;
        checks++;
        if ({tr_busy[1], tr_busy[30], tr_busy[31]} !== 3'b110)
            $display("FAIL basic_busy: c1/c30/c31=%b need 110",
                     {tr_busy[1], tr_busy[30], tr_busy[31]});
        else passed++;
        checks++;
        if ({tr_done[29], tr_done[31]} !== 2'b00)
            $display("FAIL basic_done_pulse: c29/c31=%b need 00", {tr_done[29], tr_done[31]});
        else passed++;
    endtask

    task automatic test_max(input logic cidx);
        logic [63:0] e;
        load(M57, cidx);
        run_row(M57, -1, -1);
        for (int j = 0; j <= N; j++) begin
            if (j == 0) e = 64'd1;
            else if (j == N) e = M57 - 64'd1;
            else e = M57;
            if (cidx) e = e + 64'(j);
            checks++;
            if (rmem[j] !== e)
                $display("FAIL max_c%0d_r%0d: got %h need %h", cidx, j, rmem[j], e);
            else passed++;
        end
        checks++;
        if (done_cyc !== 30)
            $display("FAIL max_done_cycle: got %0d need 30", done_cyc);
        else passed++;
    endtask

    task automatic test_issue_trace();
        logic h, l;
        logic [5:0] efn;
        logic [4:0] etag;
        load(64'd1, 1'b0);
        run_row(64'd2, -1, -1);
        for (int k = 1; k < 40; k++) begin
            h = (k <= 1 + 3 * N) && ((k - 1) % 3 == 0);
            l = (k >= 3) && (k <= 3 * N) && (k % 3 == 0);
            checks++;
            if (tr_v[k] !== (h | l))
                $display("FAIL trace_valid_c%0d: got %b need %b", k, tr_v[k], h | l);
            else passed++;
            if (h | l) begin
                efn  = h ? 6'd51 : 6'd50;
                etag = h ? {1'b0, 4'((k - 1) / 3)} : {1'b1, 4'((k - 3) / 3)};
                checks++;
                if (tr_fn[k] !== efn || tr_tag[k] !== etag || tr_dw[k] !== 1'b1)
                    $display("FAIL trace_req_c%0d: fn=%0d tag=%h dw=%b need fn=%0d tag=%h dw=1",
                             k, tr_fn[k], tr_tag[k], tr_dw[k], efn, etag);
                else passed++;
            end
        end
    endtask

    task automatic test_err_and_busy_start();
        logic [63:0] e;
        load(64'd1, 1'b0);
        corrupt = 1'b1;
        run_row(64'd2, -1, -1);
        corrupt = 1'b0;
        checks++;
        if ({tr_err[14], tr_err[16], tr_err[30], tr_err[31]} !== 4'b0111)
            $display("FAIL err_sticky: c14/c16/c30/c31=%b need 0111",
                     {tr_err[14], tr_err[16], tr_err[30], tr_err[31]});
        else passed++;
        checks++;
        if (rmem[4] !== 64'd2 || rmem[N] !== 64'd0)
            $display("FAIL err_data: r4=%h r9=%h need 2 and 0", rmem[4], rmem[N]);
        else passed++;

        load(M57, 1'b1);
        run_row(M57, 5, -1);
        checks++;
        if (tr_err[1] !== 1'b0)
            $display("FAIL err_clear: got %b need 0", tr_err[1]);
        else passed++;
        checks++;
        if (done_cyc !== 30 || wr_cnt !== 10)
            $display("FAIL busy_start_timing: done=%0d writes=%0d need 30 and 10",
                     done_cyc, wr_cnt);
        else passed++;
        for (int j = 0; j <= N; j++) begin
            e = (j == 0) ? 64'd1 : (j == N) ? M57 - 64'd1 : M57;
            e = e + 64'(j);
            checks++;
            if (rmem[j] !== e)
                $display("FAIL busy_start_r%0d: got %h need %h", j, rmem[j], e);
            else passed++;
        end
    endtask

    task automatic test_abort();
        int late_we;
        load(64'd1, 1'b0);
        run_row(64'd2, -1, 10);
        late_we = 0;
        for (int k = 11; k < 45; k++)
            if (tr_we[k] !== 1'b0) late_we++;
        checks++;
        if (late_we !== 0)
            $display("FAIL abort_no_write: got %0d late writes need 0", late_we);
        else passed++;
        checks++;
        if (tr_zero[11] !== 1'b1)
            $display("FAIL abort_outputs: all_zero=%b need 1", tr_zero[11]);
        else passed++;
        checks++;
        if (wr_cnt !== 2 || done_cyc !== -1)
            $display("FAIL abort_count: writes=%0d done=%0d need 2 and -1", wr_cnt, done_cyc);
        else passed++;

        load(64'd1, 1'b0);
        run_row(64'd2, -1, -1);
        checks++;
        if (done_cyc !== 30 || wr_cnt !== 10 || rmem[0] !== 64'd2 || rmem[8] !== 64'd2)
            $display("FAIL abort_restart: done=%0d writes=%0d r0=%h r8=%h need 30 10 2 2",
                     done_cyc, wr_cnt, rmem[0], rmem[8]);
        else passed++;
    endtask

    initial begin
        load(64'd0, 1'b0);
        test_reset();
        test_basic();
        test_max(1'b0);
        test_max(1'b1);
        test_issue_trace();
        test_err_and_busy_start();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
